// File: rtl/pad_debounce8.sv
// Eight-channel pad conditioner: two-flop synchronizer, tick-qualified stability
// counter per channel, and registered one-cycle press/release strobes.

module pad_debounce_lane #(
    parameter int STABLE_COUNT = 16,
    parameter int CNT_W        = $clog2(STABLE_COUNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sample,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                // Any sample agreeing with the current level restarts the run.
                if (sample == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    level <= sample;
                    cnt   <= '0;
                    rise  <= sample;
                    fall  <= ~sample;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

module pad_debounce8 #(
    parameter int STABLE_COUNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] pad_raw,
    output logic [7:0] pad_level,
    output logic [7:0] pad_press,
    output logic [7:0] pad_release,
    output logic       any_press
);
    localparam int NUM_LANES = 8;
    localparam int CNT_W     = $clog2(STABLE_COUNT + 1);

    logic [NUM_LANES-1:0] sync1;
    logic [NUM_LANES-1:0] sync2;

    // Synchronizer runs every clock so tick gating never adds metastability exposure.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pad_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pad_debounce_lane #(
            .STABLE_COUNT(STABLE_COUNT),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .sample(sync2[i]),
            .level (pad_level[i]),
            .rise  (pad_press[i]),
            .fall  (pad_release[i])
        );
    end

    assign any_press = |pad_press;
endmodule

// File: tb/tb_pad_debounce8.sv
// Bench for pad_debounce8: three instances (STABLE_COUNT 4, 3, 1) against a
// sliding-window reference model, plus directed literal checks.

module tb_pad_debounce8;
    localparam int ND = 3;
    localparam int SC [ND] = '{4, 3, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] pad_raw;
    logic [7:0] lvl_o [ND];
    logic [7:0] pr_o  [ND];
    logic [7:0] rl_o  [ND];
    logic       any_o [ND];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pad_debounce8 #(.STABLE_COUNT(4)) u_dut4 (
        .clk(clk), .rst(rst), .tick(tick), .pad_raw(pad_raw),
        .pad_level(lvl_o[0]), .pad_press(pr_o[0]), .pad_release(rl_o[0]), .any_press(any_o[0]));
    pad_debounce8 #(.STABLE_COUNT(3)) u_dut3 (
        .clk(clk), .rst(rst), .tick(tick), .pad_raw(pad_raw),
        .pad_level(lvl_o[1]), .pad_press(pr_o[1]), .pad_release(rl_o[1]), .any_press(any_o[1]));
    pad_debounce8 #(.STABLE_COUNT(1)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .pad_raw(pad_raw),
        .pad_level(lvl_o[2]), .pad_press(pr_o[2]), .pad_release(rl_o[2]), .any_press(any_o[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips when the last SC tick-samples since the
    // previous flip/reset all disagree with it.
    logic [7:0]  m_s1  [ND];
    logic [7:0]  m_s2  [ND];
    logic [7:0]  m_lvl [ND];
    logic [7:0]  m_pr  [ND];
    logic [7:0]  m_rl  [ND];
    logic [15:0] m_win [ND][8];
    int          m_nv  [ND][8];
    bit          started = 1'b0;

    initial begin
        logic [15:0] mask;
        forever begin
            @(posedge clk);
            for (int d = 0; d < ND; d++) begin
                mask = 16'((32'd1 << SC[d]) - 32'd1);
                if (rst) begin
                    m_s1[d] = '0; m_s2[d] = '0; m_lvl[d] = '0; m_pr[d] = '0; m_rl[d] = '0;
                    for (int i = 0; i < 8; i++) begin
                        m_win[d][i] = '0;
                        m_nv[d][i]  = 0;
                    end
                end else begin
                    m_pr[d] = '0;
                    m_rl[d] = '0;
                    if (tick) begin
                        for (int i = 0; i < 8; i++) begin
                            m_win[d][i] = {m_win[d][i][14:0], m_s2[d][i]};
                            if (m_nv[d][i] < SC[d]) m_nv[d][i]++;
                            if (m_nv[d][i] == SC[d] &&
                                (m_win[d][i] & mask) == (m_lvl[d][i] ? 16'h0 : mask)) begin
                                m_lvl[d][i] = ~m_lvl[d][i];
                                if (m_lvl[d][i]) m_pr[d][i] = 1'b1;
                                else             m_rl[d][i] = 1'b1;
                                m_nv[d][i] = 0;
                            end
                        end
                    end
                    m_s2[d] = m_s1[d];
                    m_s1[d] = pad_raw;
                end
            end
            if (rst) started = 1'b1;
            @(negedge clk);
            if (started) begin
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("model_level[%0d]", d), 32'(lvl_o[d]), 32'(m_lvl[d]));
                    chk($sformatf("model_press[%0d]", d), 32'(pr_o[d]), 32'(m_pr[d]));
                    chk($sformatf("model_release[%0d]", d), 32'(rl_o[d]), 32'(m_rl[d]));
                    chk($sformatf("model_any[%0d]", d), 32'(any_o[d]), 32'(|m_pr[d]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // Steps until pad_press[bit] on instance d; -1 if the bound expires.
    task automatic wait_press(input int d, input int b, input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            step();
            if (pr_o[d][b]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] acc;
        int n;
        int pulses;
        rst = 1'b1; tick = 1'b1; pad_raw = '0;
        @(negedge clk);

        // Reset then idle
        do_reset(3);
        chk("reset_level", 32'(lvl_o[0]), 32'h0);
        chk("reset_any", 32'(any_o[0]), 32'h0);
        acc = '0;
        repeat (50) begin
            step();
            acc |= lvl_o[0] | pr_o[0] | rl_o[0] | {7'd0, any_o[0]};
        end
        chk("idle_quiet", 32'(acc), 32'h0);

        // Clean press on bit 3, tick tied high
        pad_raw = 8'h08;
        repeat (3) step();
        chk("press_s1_edge3", 32'(pr_o[2]), 32'h08);
        repeat (2) step();
        chk("press_s4_early", 32'(pr_o[0]), 32'h00);
        step();
        chk("press_s4_edge6", 32'(pr_o[0]), 32'h08);
        chk("level_s4_edge6", 32'(lvl_o[0]), 32'h08);
        chk("any_s4_edge6", 32'(any_o[0]), 32'h1);
        step();
        chk("press_s4_onecycle", 32'(pr_o[0]), 32'h00);
        chk("level_s4_held", 32'(lvl_o[0]), 32'h08);
        pad_raw = 8'h00;
        repeat (6) step();
        chk("release_s4_edge6", 32'(rl_o[0]), 32'h08);
        chk("release_level", 32'(lvl_o[0]), 32'h00);

        // Bounce rejection on bit 0
        do_reset(1);
        pulses = 0;
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            pad_raw[0] = (k == 4) ? 1'b0 : 1'b1;
            step();
            if (pr_o[0][0]) begin
                pulses++;
                if (n < 0) n = k;
            end
        end
        chk("bounce_one_pulse", 32'(pulses), 32'd1);
        chk("bounce_press_step", 32'(n), 32'd10);

        // Tick gating: tick every 10th cycle, bit 7
        pad_raw = 8'h00;
        do_reset(1);
        pad_raw = 8'h80;
        begin
            int t1, t3, t4;
            t1 = -1; t3 = -1; t4 = -1;
            for (int k = 1; k <= 60; k++) begin
                tick = (k % 10 == 0);
                step();
                if (pr_o[2][7] && t1 < 0) t1 = k;
                if (pr_o[1][7] && t3 < 0) t3 = k;
                if (pr_o[0][7] && t4 < 0) t4 = k;
            end
            chk("gate_s1", 32'(t1), 32'd10);
            chk("gate_s3", 32'(t3), 32'd30);
            chk("gate_s4", 32'(t4), 32'd40);
        end
        tick = 1'b1;

        // Simultaneous channels
        pad_raw = 8'h00;
        do_reset(1);
        pad_raw = 8'hA5;
        repeat (6) step();
        chk("simul_press", 32'(pr_o[0]), 32'hA5);
        pad_raw = 8'h5A;
        repeat (6) step();
        chk("simul_release", 32'(rl_o[0]), 32'hA5);
        chk("simul_press2", 32'(pr_o[0]), 32'h5A);

        // Reset mid-debounce with bit 2 held
        pad_raw = 8'h00;
        do_reset(1);
        pad_raw = 8'h04;
        repeat (5) step();
        chk("midreset_none_yet", 32'(pr_o[0]), 32'h00);
        do_reset(1);
        chk("midreset_cleared", 32'(lvl_o[0]), 32'h00);
        wait_press(0, 2, 20, n);
        chk("midreset_press_step", 32'(n), 32'd6);

        // Random traffic
        pad_raw = 8'h00;
        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            if (k % 1000 < 500) tick = 1'b1;
            else                tick = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, (k % 700 < 100) ? 2 : 12) == 0) pad_raw[i] = ~pad_raw[i];
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pad_debounce8.md
# pad_debounce8

Eight-channel pad input conditioner for the drum machine front end: synchronizes eight asynchronous pad/button lines, debounces each independently with a tick-qualified stability counter, and emits clean levels plus single-cycle press/release strobes. Its `pad_press` vector feeds the downstream 8-to-3 priority encoder that selects the triggered drum voice; `any_press` qualifies that encoder's output.

## Interface
- `STABLE_COUNT`, default 16: consecutive differing sample ticks required before a debounced level changes; legal range 1..65535.
- `CNT_W`, default `$clog2(STABLE_COUNT+1)`: per-channel counter width; local, derived, not overridden.

- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: sample-enable strobe (e.g. 1 kHz divider pulse); may be tied high.
- `pad_raw` in 8: asynchronous raw pad inputs, active-high (1 = pressed).
- `pad_level` out 8: debounced pad state.
- `pad_press` out 8: one-cycle pulse per bit on debounced 0->1.
- `pad_release` out 8: one-cycle pulse per bit on debounced 1->0.
- `any_press` out 1: OR of `pad_press` bits, combinational from registered bits.

## Operation
- Synchronizer: two flops per bit, clocked every `clk` regardless of `tick`; `sync2[i]` is the stage-2 output.
- Per channel `i`: counter `cnt[i]` (CNT_W bits), debounced `pad_level[i]`.
- On cycles with `tick`=1:
  - if `sync2[i] == pad_level[i]`: `cnt[i]` <= 0.
  - else if `cnt[i] == STABLE_COUNT-1`: `pad_level[i]` <= `sync2[i]`, `cnt[i]` <= 0, and set `pad_press[i]` (rising) or `pad_release[i]` (falling) for the next cycle.
  - else `cnt[i]` <= `cnt[i]`+1.
- On cycles with `tick`=0: counters and levels hold.
- `pad_press`/`pad_release` are registered; each cycle they default to 0 unless set by the rule above. They are therefore high for exactly one `clk` cycle, the same cycle `pad_level` first shows the new value.
- Channels are fully independent; any number of bits may toggle or pulse in the same cycle.
- A single tick with the input equal to `pad_level` (bounce back) restarts that channel's count from 0. The counter never exceeds STABLE_COUNT-1, so there is no wrap-around.
- STABLE_COUNT=1: the level follows `sync2` on the first differing tick.

## Timing
- Reset (`rst`=1 at an edge): sync flops, `cnt`, `pad_level`, `pad_press` and `pad_release` are all 0; `any_press`=0. `rst` overrides `tick`.
- Reset mid-debounce: progress is discarded. A pad held high through reset release is reported as a fresh press after 2 + STABLE_COUNT qualifying cycles.
- Latency with `tick` tied high: raw change before edge 0 gives `sync2` updated after edge 2, and `pad_level`/pulse updated after edge 2+STABLE_COUNT.
- General latency: 2 clk of synchronization, then STABLE_COUNT ticks of stability.
- No handshake: strobes are fire-and-forget and must be consumed in the cycle they are high.
- Raw glitches shorter than one clk may be missed by the synchronizer. This is intended.

## Test plan
- Reset then idle: `rst` 3 cycles, `pad_raw`=0x00 -> all outputs 0 for 50 cycles; no pulses.
- Clean press, `tick` tied high, STABLE_COUNT=4: `pad_raw[3]` 0->1 before edge 0 -> `pad_level`=0x08 and `pad_press`=0x08, `any_press`=1 exactly after edge 6, for one cycle. Release gives `pad_release`=0x08 6 edges after the raw fall.
- Bounce rejection, STABLE_COUNT=4: `pad_raw[0]` pattern 1,1,1,0,1,1,1,1 (one value per tick) -> the 0 restarts the count; the level rises only after 4 consecutive 1-ticks; exactly one `pad_press[0]` pulse.
- Tick gating: `tick` every 10th cycle, STABLE_COUNT=3, `pad_raw[7]`=1 -> `pad_press[7]` on the cycle after the 3rd tick that sees `sync2[7]`=1; counter holds between ticks.
- Simultaneous channels: `pad_raw`=0xA5 in one cycle -> `pad_press`=0xA5 in a single cycle. Then `pad_raw`=0x5A -> the same cycle shows `pad_release`=0xA5 and `pad_press`=0x5A.
- Reset mid-operation: `pad_raw[2]` held high, `rst` pulsed one cycle before the count completes -> no pulse at the original time; `pad_press[2]` 2+STABLE_COUNT qualifying cycles after reset release.
